mem_stage: RTL

//  Memory stage of the 5-stage 64-bit pipeline; sits between the EX/MEM register and writeback.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_mem_wb_reg.sv | 52 +++++
 rtl/mem_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: datapath widths, FSM state encoding
// and the MEM/WB field bundle.
package mem_stage_pkg;

   localparam int unsigned DATA_W     = 64;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   typedef struct packed {
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [DATA_W-1:0]     read_data;
      logic [DATA_W-1:0]     alu_result;
      logic [REG_ADDR_W-1:0] write_reg;
   } mem_wb_t;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register; while bubble_i is set the control bits are cleared
// and the data fields hold their previous values.
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  bubble_i,
   input  logic                  mem_to_reg_i,
   input  logic                  reg_write_i,
   input  logic [DATA_W-1:0]     read_data_i,
   input  logic [DATA_W-1:0]     alu_result_i,
   input  logic [REG_ADDR_W-1:0] write_reg_i,
   output logic                  mem_to_reg_o,
   output logic                  reg_write_o,
   output logic [DATA_W-1:0]     read_data_o,
   output logic [DATA_W-1:0]     alu_result_o,
   output logic [REG_ADDR_W-1:0] write_reg_o
);

   mem_wb_t wb_q;
   mem_wb_t wb_d;

   always_comb begin
      wb_d = wb_q;
      if (bubble_i) begin
         wb_d.mem_to_reg = 1'b0;
         wb_d.reg_write  = 1'b0;
      end else begin
         wb_d.mem_to_reg = mem_to_reg_i;
         wb_d.reg_write  = reg_write_i;
         wb_d.read_data  = read_data_i;
         wb_d.alu_result = alu_result_i;
         wb_d.write_reg  = write_reg_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wb_q <= '0;
      end else begin
         wb_q <= wb_d;
      end
   end

   assign mem_to_reg_o = wb_q.mem_to_reg;
   assign reg_write_o  = wb_q.reg_write;
   assign read_data_o  = wb_q.read_data;
   assign alu_result_o = wb_q.alu_result;
   assign write_reg_o  = wb_q.write_reg;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: branch resolution, req/ready data-memory handshake with timeout,
// upstream stall and MEM/WB register. MEM_STAGE_STALL_CNT_EN adds stall_cycles.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DMEM_TIMEOUT = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Zero,
   input  logic                  GreaterThanEqualZero,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  MemtoReg,
   input  logic                  RegWrite,
   input  logic                  Branch,
   input  logic                  BranchGeq,
   input  logic [DATA_W-1:0]     WriteData,
   input  logic [DATA_W-1:0]     Address,
   input  logic [DATA_W-1:0]     ALUResult,
   input  logic [REG_ADDR_W-1:0] WriteReg,
   output logic                  PCSrc,
   output logic [DATA_W-1:0]     BranchTarget,
   output logic                  maintain,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_W-1:0]     dmem_addr,
   output logic [DATA_W-1:0]     dmem_wdata,
   input  logic                  dmem_ready,
   input  logic [DATA_W-1:0]     dmem_rdata,
   output logic                  OutMemtoReg,
   output logic                  OutRegWrite,
   output logic [DATA_W-1:0]     OutReadData,
   output logic [DATA_W-1:0]     OutALUResult,
   output logic [REG_ADDR_W-1:0] OutWriteReg,
`ifdef MEM_STAGE_STALL_CNT_EN
   output logic [31:0]           stall_cycles,
`endif
   output logic                  dmem_err
);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             access;
   logic             is_load;
   logic             timeout_hit;
   logic             complete;
   logic             abort;
   logic [DATA_W-1:0] load_data;

   assign PCSrc        = (Branch & Zero) | (BranchGeq & GreaterThanEqualZero);
   assign BranchTarget = Address;

   assign access  = MemRead | MemWrite;
   assign is_load = MemRead & ~MemWrite;

   // A ready arriving on the final wait cycle wins over the abort.
   assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(DMEM_TIMEOUT));
   assign complete    = access & (dmem_ready | timeout_hit);
   assign abort       = access & ~dmem_ready & timeout_hit;
   assign maintain    = access & ~complete;

   assign dmem_req   = access;
   assign dmem_we    = MemWrite;
   assign dmem_addr  = ALUResult;
   assign dmem_wdata = WriteData;

   assign load_data = (is_load & dmem_ready) ? dmem_rdata : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q | abort;
      case (state_q)
         ST_IDLE: begin
            if (access && !dmem_ready) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (complete || !access) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign dmem_err = err_q;

`ifdef MEM_STAGE_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (maintain && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

   mem_wb_reg u_mem_wb_reg (
      .clk_i        (clk),
      .reset_i      (reset),
      .bubble_i     (maintain),
      .mem_to_reg_i (MemtoReg),
      .reg_write_i  (RegWrite),
      .read_data_i  (load_data),
      .alu_result_i (ALUResult),
      .write_reg_i  (WriteReg),
      .mem_to_reg_o (OutMemtoReg),
      .reg_write_o  (OutRegWrite),
      .read_data_o  (OutReadData),
      .alu_result_o (OutALUResult),
      .write_reg_o  (OutWriteReg)
   );

endmodule
